// File: rtl/ascii_to_decimal.sv
// Parses a packed OLED text buffer (MSD in the top byte, pad bytes ignored) into a 32-bit
// unsigned value, scanning one byte per clock from the top byte down.
module ascii_to_decimal #(
  parameter int unsigned N_CHARS  = 64,
  parameter logic [7:0]  PAD_CHAR = 8'h02
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*N_CHARS-1:0]   ascii,
  input  logic                   load_data,
  output logic [31:0]            decimal,
  output logic                   busy,
  output logic                   complete,
  output logic                   overflow,
  output logic                   error
);

  localparam int unsigned   IdxW   = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N_CHARS - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e               state_q, state_d;
  logic [8*N_CHARS-1:0] shadow_q, shadow_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [31:0]          acc_q, acc_d;
  logic [31:0]          decimal_q, decimal_d;
  logic                 busy_q, busy_d;
  logic                 complete_q, complete_d;
  logic                 overflow_q, overflow_d;
  logic                 error_q, error_d;

  logic [7:0]  cur_byte;
  logic        is_digit;
  logic [35:0] prod;

  always_comb begin
    cur_byte = shadow_q[{idx_q, 3'b000} +: 8];
    is_digit = (cur_byte >= 8'h30) && (cur_byte <= 8'h39);
    // acc*10 as shifts in 36 bits; the low nibble of an ASCII digit is its value.
    prod     = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1) + {32'd0, cur_byte[3:0]};
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    decimal_d  = decimal_q;
    busy_d     = busy_q;
    complete_d = complete_q;
    overflow_d = overflow_q;
    error_d    = error_q;

    // A load always (re)starts the scan, including on the final scan edge.
    if (load_data) begin
      shadow_d   = ascii;
      idx_d      = IdxTop;
      acc_d      = '0;
      complete_d = 1'b0;
      overflow_d = 1'b0;
      error_d    = 1'b0;
      busy_d     = 1'b1;
      state_d    = StScan;
    end else if (state_q == StScan) begin
      if (is_digit) begin
        if (prod[35:32] != 4'd0) begin
          overflow_d = 1'b1;
          acc_d      = 32'hFFFF_FFFF;
        end else begin
          acc_d = prod[31:0];
        end
      end else if (cur_byte != PAD_CHAR) begin
        error_d = 1'b1;
      end

      if (idx_q == '0) begin
        decimal_d  = acc_d;
        complete_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      decimal_q  <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      decimal_q  <= decimal_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign decimal  = decimal_q;
  assign busy     = busy_q;
  assign complete = complete_q;
  assign overflow = overflow_q;
  assign error    = error_q;

endmodule

// File: tb/tb_ascii_to_decimal.sv
// Directed-vector bench for ascii_to_decimal; '_' in a stimulus string stands for the pad byte.
module tb_ascii_to_decimal;

  logic         clock;
  logic         reset;
  logic [511:0] ascii;
  logic         load_data;
  logic [31:0]  decimal;
  logic         busy;
  logic         complete;
  logic         overflow;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int busy_cnt;

  ascii_to_decimal dut (
    .clock    (clock),
    .reset    (reset),
    .ascii    (ascii),
    .load_data(load_data),
    .decimal  (decimal),
    .busy     (busy),
    .complete (complete),
    .overflow (overflow),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_buf(input string s);
    byte ch;
    ascii = {64{8'h02}};
    for (int i = 0; i < s.len(); i++) begin
      ch = s.getc(i);
      ascii[(63 - i) * 8 +: 8] = (ch == "_") ? 8'h02 : ch;
    end
  endtask

  // Leaves the bench 1ns after the load edge.
  task automatic do_load(input string s);
    @(negedge clock);
    set_buf(s);
    load_data = 1'b1;
    @(posedge clock);
    #1;
    load_data = 1'b0;
  endtask

  task automatic wait_complete(output int l, output int b);
    l = 0;
    b = busy ? 1 : 0;
    while (!complete && l < 200) begin
      @(posedge clock);
      #1;
      l++;
      if (busy) b++;
    end
  endtask

  task automatic run_case(input string tag, input string s, input logic [31:0] exp_dec,
                          input logic exp_ovf, input logic exp_err);
    do_load(s);
    wait_complete(lat, busy_cnt);
    check_eq({tag, "_latency"}, lat, 64);
    check_eq({tag, "_decimal"}, decimal, exp_dec);
    check_eq({tag, "_ovf_err"}, {30'd0, overflow, error}, {30'd0, exp_ovf, exp_err});
  endtask

  initial begin
    reset     = 1'b0;
    load_data = 1'b0;
    ascii     = '0;
    #22;
    check_eq("reset_outputs", {decimal[3:0], busy, complete, overflow, error}, 8'h00);
    check_eq("reset_decimal", decimal, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Shadow copy must be parsed even if ascii changes right after the load edge.
    do_load("1234");
    ascii = {64{8'h39}};
    wait_complete(lat, busy_cnt);
    check_eq("c1234_latency", lat, 64);
    check_eq("c1234_decimal", decimal, 32'd1234);
    check_eq("c1234_ovf_err", {30'd0, overflow, error}, 32'd0);
    check_eq("c1234_busy", {31'd0, busy}, 32'd0);

    do_load("");
    wait_complete(lat, busy_cnt);
    check_eq("allpad_latency", lat, 64);
    check_eq("allpad_busy_cycles", busy_cnt, 64);
    check_eq("allpad_decimal", decimal, 32'd0);
    check_eq("allpad_ovf_err", {30'd0, overflow, error}, 32'd0);

    run_case("max", "4294967295", 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_case("max_plus1", "4294967296", 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_case("bad_char", "12A4", 32'd124, 1'b0, 1'b1);
    run_case("pads", "_5_7", 32'd57, 1'b0, 1'b0);
    run_case("ovf_and_err", "99999999999Z", 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_case("zeros", "0000000000000000000000000000000000000000000000000000000000000042",
             32'd42, 1'b0, 1'b0);
    run_case("trail_pad", "9__________________", 32'd9, 1'b0, 1'b0);

    // Abort mid-scan: decimal holds the last completed value, single completion for "42".
    do_load("999");
    repeat (30) begin
      @(posedge clock);
      #1;
    end
    check_eq("abort_no_cmp", {31'd0, complete}, 32'd0);
    check_eq("abort_hold_dec", decimal, 32'd9);
    do_load("42");
    wait_complete(lat, busy_cnt);
    check_eq("abort_latency", lat, 64);
    check_eq("abort_decimal", decimal, 32'd42);

    // Load on the final scan edge wins over completion.
    do_load("5");
    repeat (63) begin
      @(posedge clock);
      #1;
    end
    check_eq("final_pre_busy", {30'd0, busy, complete}, 32'd2);
    do_load("8");
    check_eq("final_edge_no_cmp", {30'd0, busy, complete}, 32'd2);
    check_eq("final_edge_dec", decimal, 32'd42);
    wait_complete(lat, busy_cnt);
    check_eq("final_latency", lat, 64);
    check_eq("final_decimal", decimal, 32'd8);

    // Asynchronous reset mid-scan, applied away from any clock edge.
    do_load("1234");
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    #1;
    reset = 1'b0;
    #1;
    check_eq("midreset_flags", {28'd0, busy, complete, overflow, error}, 32'd0);
    check_eq("midreset_decimal", decimal, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_case("after_reset", "7", 32'd7, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
